// File: rtl/mult_unit_if.sv
// Operand/result bundle between the execute stage and mult_unit.
// The master drives the request side; the slave (multiplier) drives status and HI/LO.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sign, srca, srcb, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, sign, srca, srcb, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add 32x32 signed/unsigned multiplier feeding the HI/LO registers.
// Define MULT_RADIX4_EN to retire two multiplier bits per RUN cycle instead of one.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_unit_if.slave bus
);

  localparam int PW = 2 * WIDTH;
`ifdef MULT_RADIX4_EN
  localparam int ITERS = WIDTH / 2;
  localparam int SHIFT = 2;
`else
  localparam int ITERS = WIDTH;
  localparam int SHIFT = 1;
`endif
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic [PW-1:0]      acc_step;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             signed_mode);
    return (signed_mode && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [PW-1:0] negate(input logic [PW-1:0] p);
    return ~p + PW'(1);
  endfunction

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0] mcand3_q, mcand3_d;
  logic [WIDTH+1:0] addend4;
  logic [WIDTH+1:0] sum4;

  always_comb begin
    case (mplier_q[1:0])
      2'd1:    addend4 = {2'b00, mcand_q};
      2'd2:    addend4 = {1'b0, mcand_q, 1'b0};
      2'd3:    addend4 = mcand3_q;
      default: addend4 = '0;
    endcase
  end

  assign sum4     = {2'b00, acc_q[PW-1:WIDTH]} + addend4;
  assign acc_step = {sum4, acc_q[WIDTH-1:2]};
`else
  logic [WIDTH:0] sum2;

  // Carry out of the upper-half add shifts back in as the new MSB.
  assign sum2     = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step = {sum2, acc_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULT_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          mcand_d  = magnitude(bus.srca, bus.sign);
          mplier_d = magnitude(bus.srcb, bus.sign);
          neg_d    = bus.sign & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
`ifdef MULT_RADIX4_EN
          mcand3_d = {2'b00, mcand_d} + {1'b0, mcand_d, 1'b0};
`endif
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_step;
          mplier_d = mplier_q >> SHIFT;
          count_d  = count_q + CNT_W'(1);
          if (count_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          {hi_d, lo_d} = neg_q ? negate(acc_q) : acc_q;
          done_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULT_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULT_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Randomized and directed bench for mult_unit against a plain-arithmetic product model.
// Latency expectations follow MULT_RADIX4_EN when it is defined for the build.
module tb_mult_unit;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_unit_if #(.WIDTH(32)) bus ();

  mult_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Drive a start pulse; returns at the negedge just after the sampling edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sign  = s;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.srca  = $urandom;
    bus.srcb  = $urandom;
  endtask

  task automatic wait_done(output int k, output int bc);
    k  = 1;
    bc = 0;
    while (bus.done !== 1'b1 && k <= LAT + 20) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    int k, bc;
    logic [63:0] p;
    start_op(a, b, s);
    wait_done(k, bc);
    p      = ref_prod(a, b, s);
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    check("latency", 64'(k), 64'(LAT + 1));
    check("busy_cycles", 64'(bc), 64'(LAT));
    check("hi", 64'(bus.hi), 64'(exp_hi));
    check("lo", 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    check("done_pulse_width", 64'(bus.done), 64'(0));
  endtask

  initial begin
    int dones;
    n_checks   = 0;
    n_errors   = 0;
    bus.start  = 1'b0;
    bus.sign   = 1'b0;
    bus.srca   = '0;
    bus.srcb   = '0;
    bus.cancel = 1'b0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    do_mul(32'h0000_0007, 32'h0000_0006, 1'b0);
    do_mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1);
    do_mul(32'h8000_0000, 32'h0000_0001, 1'b1);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_mul(32'h0000_0000, 32'h1234_5678, 1'b1);
    for (int i = 0; i < 16; i++) begin
      do_mul($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Cancel in RUN after a completed 7*6.
    do_mul(32'd7, 32'd6, 1'b0);
    start_op(32'd3, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_run_busy", 64'(bus.busy), 64'(0));
    dones = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("cancel_run_no_done", 64'(dones), 64'(0));
    check("cancel_run_hi", 64'(bus.hi), 64'(exp_hi));
    check("cancel_run_lo", 64'(bus.lo), 64'(exp_lo));

    // Cancel landing in the DONE cycle suppresses the write.
    start_op(32'd9, 32'd9, 1'b0);
    repeat (LAT - 1) @(negedge clk);
    check("done_state_busy", 64'(bus.busy), 64'(1));
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_done_busy", 64'(bus.busy), 64'(0));
    check("cancel_done_done", 64'(bus.done), 64'(0));
    check("cancel_done_hi", 64'(bus.hi), 64'(exp_hi));
    check("cancel_done_lo", 64'(bus.lo), 64'(exp_lo));

    // Start and cancel together in IDLE.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.srca   = 32'd11;
    bus.srcb   = 32'd11;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("start_cancel_idle_busy", 64'(bus.busy), 64'(0));
    repeat (2) @(negedge clk);
    check("start_cancel_idle_busy2", 64'(bus.busy), 64'(0));

    // A second start while busy is ignored.
    start_op(32'd2, 32'd2, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.srca  = 32'd5;
    bus.srcb  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    exp_hi = 32'd0;
    exp_lo = 32'd4;
    check("ignored_start_dones", 64'(dones), 64'(1));
    check("ignored_start_hi", 64'(bus.hi), 64'(exp_hi));
    check("ignored_start_lo", 64'(bus.lo), 64'(exp_lo));

    // Asynchronous reset in the middle of a run.
    do_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    start_op(32'd13, 32'd17, 1'b0);
    repeat (19) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'(0));
    check("async_rst_done", 64'(bus.done), 64'(0));
    check("async_rst_hi", 64'(bus.hi), 64'(0));
    check("async_rst_lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    do_mul(32'd1, 32'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
